// File: rtl/lcd_scan.sv
// Z88 LCD scan-out: 800x525 raster with the 640x256 Z88 window
// line-doubled x4 from a nibble-wide VRAM into rows 112..367.
module lcd_scan (
  input  logic        mck,
  input  logic        rin,
  input  logic        pix_ce,
  input  logic        lcdon,
  output logic [13:0] vram_a,
  input  logic [3:0]  vram_di,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pix,
  output logic        sof
);

  localparam logic [9:0] H_ACT   = 10'd640;
  localparam logic [9:0] H_SS    = 10'd656;
  localparam logic [9:0] H_SE    = 10'd751;
  localparam logic [9:0] H_MAX   = 10'd799;
  localparam logic [9:0] H_LAST  = 10'd636;
  localparam logic [9:0] V_ACT   = 10'd480;
  localparam logic [9:0] V_SS    = 10'd490;
  localparam logic [9:0] V_SE    = 10'd491;
  localparam logic [9:0] V_MAX   = 10'd524;
  localparam logic [9:0] WIN_TOP = 10'd112;
  localparam logic [9:0] WIN_BOT = 10'd368;

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [3:0]  nib;

  logic        h_wrap;
  logic        v_wrap;
  logic [9:0]  v_nxt;
  logic        h_act;
  logic        v_act;
  logic        v_win;
  logic        wnd;
  logic        hs_n;
  logic        vs_n;
  logic [7:0]  grp_nxt;
  logic [13:0] fetch_a;

  function automatic logic [5:0] zline(input logic [9:0] v);
    logic [9:0] d;
    d = v - WIN_TOP;
    if (v >= WIN_TOP && v < WIN_BOT)
      return d[7:2];
    return 6'd0;
  endfunction

  always_comb begin
    h_wrap  = (hcnt == H_MAX);
    v_wrap  = (vcnt == V_MAX);
    v_nxt   = v_wrap ? 10'd0 : vcnt + 10'd1;
    h_act   = (hcnt < H_ACT);
    v_act   = (vcnt < V_ACT);
    v_win   = (vcnt >= WIN_TOP) && (vcnt < WIN_BOT);
    wnd     = h_act && v_win && lcdon;
    hs_n    = !((hcnt >= H_SS) && (hcnt <= H_SE));
    vs_n    = !((vcnt >= V_SS) && (vcnt <= V_SE));
    grp_nxt = hcnt[9:2] + 8'd1;
    // Past the last visible group, prefetch group 0 of the next row.
    if (hcnt < H_LAST)
      fetch_a = {zline(vcnt), grp_nxt};
    else
      fetch_a = {zline(v_nxt), 8'd0};
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      hcnt   <= '0;
      vcnt   <= '0;
      nib    <= '0;
      vram_a <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      de     <= 1'b0;
      pix    <= 1'b0;
      sof    <= 1'b0;
    end else begin
      sof <= 1'b0;
      if (pix_ce) begin
        hcnt <= h_wrap ? 10'd0 : hcnt + 10'd1;
        if (h_wrap)
          vcnt <= v_nxt;
        de    <= h_act && v_act;
        hsync <= hs_n;
        vsync <= vs_n;
        pix   <= wnd & nib[~hcnt[1:0]];
        sof   <= h_wrap && v_wrap;
        if (hcnt[1:0] == 2'd3)
          nib <= vram_di;
        if (hcnt[1:0] == 2'd0)
          vram_a <= fetch_a;
      end
    end
  end

endmodule

// File: tb/tb_lcd_scan.sv
// Bench for lcd_scan: reset vector table, then raster segments
// checked pix_ce by pix_ce against a scoreboard of expected outputs.
module tb_lcd_scan;

  logic        mck = 1'b0;
  logic        rin;
  logic        pix_ce;
  logic        lcdon;
  logic [13:0] vram_a;
  logic [3:0]  vram_di;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        pix;
  logic        sof;

  int checks = 0;
  int passed = 0;
  int mode;
  int mh, mv;
  bit pok, aok;
  logic [13:0] ea;
  int hs_lo;
  int sof_seen;
  logic [9:0] jh, jv;

  typedef struct {
    logic [13:0] a;
    bit          a_ok;
    logic        hs, vs, de, px;
    bit          px_ok;
    logic        sof;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic        rin, ce;
    logic [13:0] a;
    logic        hs, vs, de, px, sof;
  } vec_t;

  typedef struct {
    int h0, v0, n, md, off_lo, off_hi;
  } seg_t;

  lcd_scan dut (
    .mck     (mck),
    .rin     (rin),
    .pix_ce  (pix_ce),
    .lcdon   (lcdon),
    .vram_a  (vram_a),
    .vram_di (vram_di),
    .hsync   (hsync),
    .vsync   (vsync),
    .de      (de),
    .pix     (pix),
    .sof     (sof)
  );

  always #5 mck = ~mck;

  function automatic logic [3:0] vram_f(int line, int idx, int md);
    logic [7:0] l, i;
    l = line[7:0];
    i = idx[7:0];
    case (md)
      0:       return {l[1:0], i[1:0]};
      1:       return 4'hF;
      default: return {l[2] ^ i[5], i[4:2]};
    endcase
  endfunction

  always @(posedge mck)
    vram_di <= vram_f(int'(vram_a[13:8]), int'(vram_a[7:0]), mode);

  function automatic int zl(int v);
    return (v >= 112 && v < 368) ? (v - 112) >> 2 : 0;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, req);
  endtask

  task automatic cmp(string nm, exp_t e);
    logic [18:0] act, req;
    act = {vram_a, hsync, vsync, de, pix, sof};
    req = {e.a, e.hs, e.vs, e.de, e.px, e.sof};
    if (!e.a_ok) begin
      act[18:5] = '0;
      req[18:5] = '0;
    end
    if (!e.px_ok) begin
      act[1] = 1'b0;
      req[1] = 1'b0;
    end
    check(nm, 32'(act), 32'(req));
  endtask

  task automatic pulse();
    exp_t e;
    logic [3:0] n;
    bit wnd;
    int h, v;
    @(negedge mck);
    pix_ce = 1'b1;
    h = mh;
    v = mv;
    e.de  = (h < 640) && (v < 480);
    e.hs  = !(h >= 656 && h <= 751);
    e.vs  = !(v >= 490 && v <= 491);
    wnd   = (h < 640) && (v >= 112) && (v < 368) && lcdon;
    n     = vram_f(zl(v), h >> 2, mode);
    e.px  = wnd & n[3 - (h % 4)];
    e.px_ok = pok || !wnd;
    e.sof = (h == 799) && (v == 524);
    if (h % 4 == 0) begin
      if (h < 636) ea = {6'(zl(v)), 8'((h >> 2) + 1)};
      else         ea = {6'(zl((v + 1) % 525)), 8'd0};
      aok = 1'b1;
    end
    e.a    = ea;
    e.a_ok = aok;
    q.push_back(e);
    if (h == 799) begin
      pok = 1'b1;
      mh  = 0;
      mv  = (v == 524) ? 0 : v + 1;
    end else begin
      mh = h + 1;
    end
    @(posedge mck);
    #1;
    if (q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard: queue empty at h=%0d v=%0d", h, v);
    end else begin
      e = q.pop_front();
      cmp($sformatf("out h=%0d v=%0d", h, v), e);
    end
    if (!hsync) hs_lo++;
    if (sof) sof_seen++;
    if (h == 632)
      check($sformatf("addr idx h=632 v=%0d", v), 32'(vram_a[7:0]), 32'd159);
    if (h == 636 && v == 115)
      check("addr h=636 v=115", 32'(vram_a), 32'h0100);
    if (h == 636 && v == 367)
      check("addr h=636 v=367", 32'(vram_a), 32'h0000);
    @(negedge mck);
    pix_ce = 1'b0;
    @(posedge mck);
    #1;
    e.sof = 1'b0;
    cmp($sformatf("hold h=%0d v=%0d", h, v), e);
  endtask

  task automatic jump(int h, int v);
    @(negedge mck);
    pix_ce = 1'b0;
    jh = 10'(h);
    jv = 10'(v);
    force dut.hcnt = jh;
    force dut.vcnt = jv;
    @(posedge mck);
    #1;
    release dut.hcnt;
    release dut.vcnt;
    mh  = h;
    mv  = v;
    pok = 1'b0;
    aok = 1'b0;
  endtask

  vec_t vt[3];
  seg_t sg[7];

  initial begin
    exp_t r;
    rin    = 1'b1;
    pix_ce = 1'b0;
    lcdon  = 1'b1;
    mode   = 0;
    hs_lo  = 0;
    sof_seen = 0;

    vt[0] = '{rin: 1, ce: 0, a: 0, hs: 1, vs: 1, de: 0, px: 0, sof: 0};
    vt[1] = '{rin: 1, ce: 1, a: 0, hs: 1, vs: 1, de: 0, px: 0, sof: 0};
    vt[2] = '{rin: 0, ce: 0, a: 0, hs: 1, vs: 1, de: 0, px: 0, sof: 0};
    for (int i = 0; i < 3; i++) begin
      @(negedge mck);
      rin    = vt[i].rin;
      pix_ce = vt[i].ce;
      @(posedge mck);
      #1;
      check($sformatf("reset vec %0d", i),
            32'({vram_a, hsync, vsync, de, pix, sof}),
            32'({vt[i].a, vt[i].hs, vt[i].vs, vt[i].de, vt[i].px, vt[i].sof}));
    end

    mh = 0; mv = 0; pok = 1'b1; aok = 1'b1; ea = '0;

    sg[0] = '{h0: -1,  v0: 0,   n: 1700, md: 0, off_lo: 0,   off_hi: 0};
    sg[1] = '{h0: 700, v0: 109, n: 6400, md: 0, off_lo: 0,   off_hi: 0};
    sg[2] = '{h0: 700, v0: 364, n: 4000, md: 1, off_lo: 0,   off_hi: 0};
    sg[3] = '{h0: 700, v0: 478, n: 2400, md: 0, off_lo: 0,   off_hi: 0};
    sg[4] = '{h0: 700, v0: 488, n: 3200, md: 1, off_lo: 0,   off_hi: 0};
    sg[5] = '{h0: 760, v0: 523, n: 900,  md: 0, off_lo: 0,   off_hi: 0};
    sg[6] = '{h0: 700, v0: 199, n: 1800, md: 2, off_lo: 300, off_hi: 700};

    for (int s = 0; s < 7; s++) begin
      if (sg[s].h0 >= 0) jump(sg[s].h0, sg[s].v0);
      mode = sg[s].md;
      sof_seen = 0;
      for (int i = 0; i < sg[s].n; i++) begin
        lcdon = !(i >= sg[s].off_lo && i < sg[s].off_hi);
        pulse();
      end
      lcdon = 1'b1;
      if (s == 0) check("hsync low count 2 lines", 32'(hs_lo), 32'd192);
      if (s == 5) check("sof count across wrap", 32'(sof_seen), 32'd1);
    end

    jump(300, 250);
    @(negedge mck);
    rin = 1'b1;
    pix_ce = 1'b1;
    @(posedge mck);
    #1;
    r = '{a: 14'd0, a_ok: 1, hs: 1, vs: 1, de: 0, px: 0, px_ok: 1, sof: 0};
    cmp("mid-frame reset", r);
    @(negedge mck);
    rin = 1'b0;
    pix_ce = 1'b0;
    @(posedge mck);
    #1;
    cmp("after reset hold", r);
    mh = 0; mv = 0; pok = 1'b1; aok = 1'b1; ea = '0;
    sof_seen = 0;
    for (int i = 0; i < 1000; i++) pulse();
    check("no sof after reset restart", 32'(sof_seen), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lcd_scan.md
LCD_SCAN -- requirements
Module: lcd_scan

Interface
REQ-001 mck  input  1  master clock; all state changes on its rising edge.
REQ-002 rin  input  1  reset; synchronous, active-high.
REQ-003 pix_ce  input  1  pixel clock enable; one pulse per output pixel; pulses at least 2 mck apart.
REQ-004 lcdon  input  1  display enable; 0 blanks the Z88 window; timing keeps running.
REQ-005 vram_a  output  14  VRAM frame-buffer read address: [13:8] Z88 line 0-63, [7:0] nibble index 0-159.
REQ-006 vram_di  input  4  VRAM read data; valid 1 mck after vram_a changes; bit 3 is the leftmost pixel.
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 de  output  1  display-enable (active video), active-high.
REQ-010 pix  output  1  pixel; 1 = lit (dark LCD dot), 0 = background/border.
REQ-011 sof  output  1  start-of-frame strobe, one mck wide.

Function
REQ-012 hcnt SHALL count 0..799 and vcnt 0..524, advancing only on pix_ce.
REQ-013 hcnt SHALL wrap 799->0 and increment vcnt; vcnt SHALL wrap 524->0 on the same pix_ce that hcnt wraps.
REQ-014 All outputs SHALL be registered and update only on pix_ce; each reflects the (hcnt,vcnt) value current before that pix_ce.
REQ-015 de SHALL be 1 iff hcnt<640 and vcnt<480.
REQ-016 hsync SHALL be 0 iff 656<=hcnt<=751.
REQ-017 vsync SHALL be 0 iff 490<=vcnt<=491.
REQ-018 Window wnd SHALL be hcnt<640 and 112<=vcnt<368 and lcdon=1.
REQ-019 zline(v) SHALL be (v-112)>>2 (6 bits) for 112<=v<368, else 0; each Z88 line is shown on 4 consecutive rows.
REQ-020 Pixel group g=hcnt>>2 SHALL use the nibble register nib.
REQ-021 On pix_ce, pix SHALL be set to wnd AND nib[3-hcnt[1:0]], giving MSB-first order.
REQ-022 On pix_ce with hcnt[1:0]=3, nib SHALL load vram_di; this is the nibble for group (hcnt+1)>>2, or group 0 of the next row when hcnt=799.
REQ-023 On pix_ce with hcnt[1:0]=0 and hcnt<636, vram_a SHALL become {zline(vcnt), (hcnt>>2)+1}.
REQ-024 On pix_ce with hcnt[1:0]=0 and hcnt>=636, vram_a SHALL become {zline(vcnt+1 mod 525), 8'd0}.
REQ-025 vram_a SHALL hold between updates; the 3-pix_ce gap from address update to nib load guarantees read latency is met.
REQ-026 The nibble index SHALL never exceed 159 (the last update at hcnt=632 gives index 159).
REQ-027 sof SHALL pulse 1 for exactly one mck on the pix_ce where (hcnt,vcnt) wraps from (799,524) to (0,0); otherwise 0.
REQ-028 lcdon changes SHALL take effect at the next pix_ce with no timing disturbance; while lcdon=0, pix=0 and VRAM fetches continue.
REQ-029 No pix_ce SHALL mean no state change (outputs hold).

Reset
REQ-030 rin=1 SHALL set hcnt=0, vcnt=0, nib=0, vram_a=0, hsync=1, vsync=1, de=0, pix=0, sof=0, overriding pix_ce.
REQ-031 Reset mid-frame SHALL restart timing at (0,0) on the first pix_ce after rin falls; no sof pulse for that restart.
REQ-032 The first visible Z88 row (vcnt=112) SHALL be fetched correctly after reset, because rows 0-111 are border.

Verification
REQ-033 Reset release, pix_ce every 4 mck for 420000 pulses -> hsync low 96 pix_ce per line, vsync low lines 490-491, sof once per 420000 pix_ce, de high 640x480 per frame.
REQ-034 VRAM model with 1-mck latency, nibble={line[1:0],idx[1:0]} pattern -> pixel (x,y) in window equals VRAM[(y-112)>>2][x>>2] bit 3-(x%4); rows 112-115 identical.
REQ-035 All-ones VRAM, lcdon=1 -> pix=1 exactly for hcnt 0-639, vcnt 112-367; pix=0 in border and blanking.
REQ-036 lcdon driven 0 at vcnt=200 -> pix=0 from next pix_ce, hsync/vsync/de unchanged; lcdon=1 again -> pixels resume with correct data.
REQ-037 rin pulsed 1 mck at hcnt=300, vcnt=250 -> all outputs at reset values next mck; timing restarts at (0,0); no sof.
REQ-038 Address check: at hcnt=632 vram_a[7:0]=159; at hcnt=636, vcnt=115 vram_a={6'd1,8'd0}; at hcnt=636, vcnt=367 vram_a=0.
